// File: rtl/fm_axi_reg_master.sv
// ============================================================================
//  Module   : fm_axi_reg_master
//  Purpose  : Single-outstanding 32-bit AXI4 register master (one command at a
//             time, one-beat bursts). Optional abort timer: FM_AXI_REG_MASTER_TIMEOUT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_axi_reg_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_axi,
  input  logic                      reset_axi_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error,
  output logic [AXI_ADDR_WIDTH-1:0] master_readMOSI_address,
  output logic                      master_readMOSI_address_valid,
  output logic                      master_readMOSI_ready_for_data,
  output logic [3:0]                master_readMOSI_address_ID,
  output logic [7:0]                master_readMOSI_burst_length,
  output logic [2:0]                master_readMOSI_burst_size,
  output logic [1:0]                master_readMOSI_burst_type,
  output logic                      master_readMOSI_lock_type,
  output logic [3:0]                master_readMOSI_cache_type,
  output logic [3:0]                master_readMOSI_qos,
  output logic [3:0]                master_readMOSI_region,
  output logic [3:0]                master_readMOSI_address_user,
  output logic [2:0]                master_readMOSI_protection_type,
  input  logic                      master_readMISO_ready_for_address,
  input  logic [31:0]               master_readMISO_data,
  input  logic                      master_readMISO_data_valid,
  input  logic [1:0]                master_readMISO_response,
  output logic [AXI_ADDR_WIDTH-1:0] master_writeMOSI_address,
  output logic                      master_writeMOSI_address_valid,
  output logic [31:0]               master_writeMOSI_data,
  output logic                      master_writeMOSI_data_valid,
  output logic                      master_writeMOSI_ready_for_response,
  output logic [3:0]                master_writeMOSI_address_ID,
  output logic [7:0]                master_writeMOSI_burst_length,
  output logic [2:0]                master_writeMOSI_burst_size,
  output logic [1:0]                master_writeMOSI_burst_type,
  output logic                      master_writeMOSI_lock_type,
  output logic [3:0]                master_writeMOSI_cache_type,
  output logic [3:0]                master_writeMOSI_qos,
  output logic [3:0]                master_writeMOSI_region,
  output logic [3:0]                master_writeMOSI_address_user,
  output logic [2:0]                master_writeMOSI_protection_type,
  output logic [3:0]                master_writeMOSI_write_ID,
  output logic [3:0]                master_writeMOSI_data_user,
  output logic [3:0]                master_writeMOSI_data_write_strobe,
  output logic                      master_writeMOSI_last,
  input  logic                      master_writeMISO_ready_for_address,
  input  logic                      master_writeMISO_ready_for_data,
  input  logic                      master_writeMISO_response_valid,
  input  logic [1:0]                master_writeMISO_response
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_AR  = 3'd1,
    RD_R   = 3'd2,
    WR_AWW = 3'd3,
    WR_B   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [31:0]               rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;
  logic                      aw_now, w_now;

  // Only the SLVERR/DECERR bit of each response matters.
  logic unused_bits;
  assign unused_bits = &{1'b0, master_readMISO_response[0],
                         master_writeMISO_response[0], 16'(TIMEOUT_CYCLES)};

`ifdef FM_AXI_REG_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;

  // Count restarts at zero on the first busy cycle after IDLE.
  always_comb begin
    to_cnt_d = (state_q == IDLE) ? 16'd0 : to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) to_cnt_q <= 16'd0;
    else              to_cnt_q <= to_cnt_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    aw_now      = aw_done_q | master_writeMISO_ready_for_address;
    w_now       = w_done_q  | master_writeMISO_ready_for_data;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          state_d = cmd_write ? WR_AWW : RD_AR;
        end
      end
      RD_AR: if (master_readMISO_ready_for_address) state_d = RD_R;
      RD_R: begin
        if (master_readMISO_data_valid) begin
          rsp_rdata_d = master_readMISO_data;
          rsp_error_d = master_readMISO_response[1];
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WR_AWW: begin
        // AW and W complete independently; both may land in the same cycle.
        aw_done_d = aw_now;
        w_done_d  = w_now;
        if (aw_now && w_now) state_d = WR_B;
      end
      WR_B: begin
        if (master_writeMISO_response_valid) begin
          rsp_rdata_d = 32'd0;
          rsp_error_d = master_writeMISO_response[1];
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FM_AXI_REG_MASTER_TIMEOUT_EN
    if (state_q != IDLE && to_cnt_q == TO_LAST) begin
      rsp_rdata_d = 32'hDEAD_DEAD;
      rsp_error_d = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_axi or negedge reset_axi_n) begin
    if (!reset_axi_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  assign master_readMOSI_address             = addr_q;
  assign master_readMOSI_address_valid       = (state_q == RD_AR);
  assign master_readMOSI_ready_for_data      = (state_q == RD_R);
  assign master_writeMOSI_address            = addr_q;
  assign master_writeMOSI_data               = wdata_q;
  assign master_writeMOSI_address_valid      = (state_q == WR_AWW) && !aw_done_q;
  assign master_writeMOSI_data_valid         = (state_q == WR_AWW) && !w_done_q;
  assign master_writeMOSI_ready_for_response = (state_q == WR_B);

  // Single-beat, 4-byte, INCR, non-privileged accesses.
  assign master_readMOSI_address_ID       = 4'd0;
  assign master_readMOSI_burst_length     = 8'd0;
  assign master_readMOSI_burst_size       = 3'b010;
  assign master_readMOSI_burst_type       = 2'b01;
  assign master_readMOSI_lock_type        = 1'b0;
  assign master_readMOSI_cache_type       = 4'd0;
  assign master_readMOSI_qos              = 4'd0;
  assign master_readMOSI_region           = 4'd0;
  assign master_readMOSI_address_user     = 4'd0;
  assign master_readMOSI_protection_type  = 3'd0;
  assign master_writeMOSI_address_ID      = 4'd0;
  assign master_writeMOSI_burst_length    = 8'd0;
  assign master_writeMOSI_burst_size      = 3'b010;
  assign master_writeMOSI_burst_type      = 2'b01;
  assign master_writeMOSI_lock_type       = 1'b0;
  assign master_writeMOSI_cache_type      = 4'd0;
  assign master_writeMOSI_qos             = 4'd0;
  assign master_writeMOSI_region          = 4'd0;
  assign master_writeMOSI_address_user    = 4'd0;
  assign master_writeMOSI_protection_type = 3'd0;
  assign master_writeMOSI_write_ID        = 4'd0;
  assign master_writeMOSI_data_user       = 4'd0;
  assign master_writeMOSI_data_write_strobe = 4'hF;
  assign master_writeMOSI_last            = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_fm_axi_reg_master.sv
// ============================================================================
//  Module   : tb_fm_axi_reg_master
//  Purpose  : Directed self-checking bench for fm_axi_reg_master
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fm_axi_reg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, wdata_o, rdata;
  logic        arvalid, rready, arready, rvalid;
  logic [1:0]  rresp, bresp;
  logic        awvalid, wvalid, bready, awready, wready, bvalid;
  logic [3:0]  r_id, r_cache, r_qos, r_region, r_user;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_size, r_prot, w_size, w_prot;
  logic [1:0]  r_burst, w_burst;
  logic        r_lock, w_lock, w_last;
  logic [3:0]  w_id, w_cache, w_qos, w_region, w_user, w_wid, w_duser, w_strb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fm_axi_reg_master #(.AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_axi(clk), .reset_axi_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .master_readMOSI_address(araddr), .master_readMOSI_address_valid(arvalid),
    .master_readMOSI_ready_for_data(rready),
    .master_readMOSI_address_ID(r_id), .master_readMOSI_burst_length(r_len),
    .master_readMOSI_burst_size(r_size), .master_readMOSI_burst_type(r_burst),
    .master_readMOSI_lock_type(r_lock), .master_readMOSI_cache_type(r_cache),
    .master_readMOSI_qos(r_qos), .master_readMOSI_region(r_region),
    .master_readMOSI_address_user(r_user), .master_readMOSI_protection_type(r_prot),
    .master_readMISO_ready_for_address(arready), .master_readMISO_data(rdata),
    .master_readMISO_data_valid(rvalid), .master_readMISO_response(rresp),
    .master_writeMOSI_address(awaddr), .master_writeMOSI_address_valid(awvalid),
    .master_writeMOSI_data(wdata_o), .master_writeMOSI_data_valid(wvalid),
    .master_writeMOSI_ready_for_response(bready),
    .master_writeMOSI_address_ID(w_id), .master_writeMOSI_burst_length(w_len),
    .master_writeMOSI_burst_size(w_size), .master_writeMOSI_burst_type(w_burst),
    .master_writeMOSI_lock_type(w_lock), .master_writeMOSI_cache_type(w_cache),
    .master_writeMOSI_qos(w_qos), .master_writeMOSI_region(w_region),
    .master_writeMOSI_address_user(w_user), .master_writeMOSI_protection_type(w_prot),
    .master_writeMOSI_write_ID(w_wid), .master_writeMOSI_data_user(w_duser),
    .master_writeMOSI_data_write_strobe(w_strb), .master_writeMOSI_last(w_last),
    .master_writeMISO_ready_for_address(awready),
    .master_writeMISO_ready_for_data(wready),
    .master_writeMISO_response_valid(bvalid), .master_writeMISO_response(bresp)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 32'd0;
    slave_idle();
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_araddr", araddr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);

    // Zero-wait write, BVALID left high even outside WR_B
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001;
    @(negedge clk);
    cmd_valid = 0;
    check("t1_awvalid", awvalid, 1);
    check("t1_wvalid", wvalid, 1);
    check("t1_awaddr", awaddr, 32'h10);
    check("t1_wdata", wdata_o, 32'hA5A5_0001);
    check("t1_cmd_ready", cmd_ready, 0);
    check("t1_strobe", w_strb, 4'hF);
    check("t1_last", w_last, 1);
    check("t1_size", w_size, 3'b010);
    check("t1_burst", r_burst, 2'b01);
    @(negedge clk);
    check("t1_bready", bready, 1);
    check("t1_aw_drop", awvalid, 0);
    check("t1_rsp_early", rsp_valid, 0);
    @(negedge clk);
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_error", rsp_error, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("t1_rsp_pulse", rsp_valid, 0);
    check("t1_idle", cmd_ready, 1);
    slave_idle();

    // Read with ARREADY after 4 wait cycles; early RVALID must be ignored
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h14;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      check($sformatf("t2_arvalid_%0d", k), arvalid, 1);
      check($sformatf("t2_no_rsp_%0d", k), rsp_valid, 0);
      if (k == 3) begin rvalid = 1; rdata = 32'hBADB_AD00; rresp = 2'b10; end
      if (k == 5) begin arready = 1; rdata = 32'h1234_5678; rresp = 2'b00; end
    end
    check("t2_araddr", araddr, 32'h14);
    @(negedge clk);
    arready = 0;
    check("t2_ar_drop", arvalid, 0);
    check("t2_rready", rready, 1);
    @(negedge clk);
    rvalid = 0;
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
    check("t2_rsp_error", rsp_error, 0);
    check("t2_rready_drop", rready, 0);
    @(negedge clk);
    check("t2_rsp_pulse", rsp_valid, 0);
    slave_idle();

    // Write: WREADY two cycles ahead of AWREADY
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h0BAD_CAFE;
    @(negedge clk);
    cmd_valid = 0;
    check("t3_aw_c1", awvalid, 1);
    check("t3_w_c1", wvalid, 1);
    wready = 1;
    @(negedge clk);
    wready = 0;
    check("t3_w_drop", wvalid, 0);
    check("t3_aw_hold2", awvalid, 1);
    @(negedge clk);
    check("t3_w_still_low", wvalid, 0);
    check("t3_aw_hold3", awvalid, 1);
    check("t3_no_bready", bready, 0);
    awready = 1;
    @(negedge clk);
    awready = 0;
    check("t3_aw_drop", awvalid, 0);
    check("t3_bready", bready, 1);
    check("t3_no_rsp", rsp_valid, 0);
    bvalid = 1;
    @(negedge clk);
    bvalid = 0;
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_error", rsp_error, 0);
    check("t3_bready_drop", bready, 0);
    @(negedge clk);
    check("t3_single_rsp", rsp_valid, 0);

    // Read SLVERR with cmd_valid held through busy, then back-to-back command
    arready = 1; rvalid = 1; rresp = 2'b10; rdata = 32'hCAFE_F00D;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
    @(negedge clk);
    check("t4_busy1", cmd_ready, 0);
    check("t4_arvalid", arvalid, 1);
    @(negedge clk);
    check("t4_busy2", cmd_ready, 0);
    check("t4_rready", rready, 1);
    @(negedge clk);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_error", rsp_error, 1);
    check("t4_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
    check("t4_ready_again", cmd_ready, 1);
    cmd_addr = 32'h34; rresp = 2'b00; rdata = 32'h1111_2222;
    @(negedge clk);
    cmd_valid = 0;
    check("t4_second_ar", arvalid, 1);
    check("t4_second_addr", araddr, 32'h34);
    check("t4_no_rsp", rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    slave_idle();
    check("t4_rsp2_valid", rsp_valid, 1);
    check("t4_rsp2_error", rsp_error, 0);
    check("t4_rsp2_rdata", rsp_rdata, 32'h1111_2222);
    @(negedge clk);
    check("t4_rsp2_pulse", rsp_valid, 0);
    check("t4_rdata_stable", rsp_rdata, 32'h1111_2222);
    check("t4_error_stable", rsp_error, 0);

`ifdef FM_AXI_REG_MASTER_TIMEOUT_EN
    // Write whose B channel never answers
    awready = 1; wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h5;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cmd_valid = 0;
      check($sformatf("t5_wait_%0d", k), rsp_valid, 0);
      if (k == 2) check("t5_bready", bready, 1);
    end
    @(negedge clk);
    check("t5_rsp_valid", rsp_valid, 1);
    check("t5_rsp_error", rsp_error, 1);
    check("t5_rsp_rdata", rsp_rdata, 32'hDEAD_DEAD);
    check("t5_bready_drop", bready, 0);
    check("t5_idle", cmd_ready, 1);
    slave_idle();
    @(negedge clk);
    check("t5_rsp_pulse", rsp_valid, 0);
`endif

    // Reset while waiting in RD_R
    arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40;
    @(negedge clk);
    cmd_valid = 0;
    check("t6_arvalid", arvalid, 1);
    @(negedge clk);
    check("t6_rready", rready, 1);
    rvalid = 1; rdata = 32'h77;
    rst_n = 1'b0;
    #1;
    check("t6_async_rready", rready, 0);
    check("t6_async_ready", cmd_ready, 1);
    check("t6_async_addr", araddr, 0);
    check("t6_async_rdata", rsp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_no_rsp_%0d", k), rsp_valid, 0);
      check($sformatf("t6_ready_%0d", k), cmd_ready, 1);
      check($sformatf("t6_rready_%0d", k), rready, 0);
    end
    slave_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
